// File: rtl/onehot_rr_arbiter_pkg.sv
// onehot_pkg: shared state type and circular one-hot selection helpers
package onehot_pkg;
  localparam int MAX_N = 64;
  localparam int MAX_W = 6;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) if (oh[i]) r = r | i;
    return r;
  endfunction
  // Scans ptr, ptr+1, ... wrapping at n, and returns the first requester as one-hot.
  function automatic logic [MAX_N-1:0] rr_select(input logic [MAX_N-1:0] req, input int ptr, input int n);
    logic [MAX_N-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      k = (ptr + i >= n) ? ptr + i - n : ptr + i;
      if (i < n && r == '0 && req[k[MAX_W-1:0]]) r[k[MAX_W-1:0]] = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// onehot_rr_arbiter_if: request vector in, registered one-hot select and index out
interface onehot_rr_arbiter_if #(parameter int N = 4, parameter int IDXW = $clog2(N));
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic gnt_valid_o;
  logic [IDXW-1:0] gnt_idx_o;
  modport master(input req_i, output gnt_o, gnt_valid_o, gnt_idx_o);
  modport slave(output req_i, input gnt_o, gnt_valid_o, gnt_idx_o);
endinterface

// File: rtl/onehot_rr_arbiter_pick.sv
// rr_priority_pick: combinational circular priority picker starting at ptr
module rr_priority_pick
  import onehot_pkg::*;
#(
  parameter int N = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  logic [MAX_N-1:0] sel;
  assign sel = rr_select(MAX_N'(req), int'(ptr), N);
  assign onehot = sel[N-1:0];
  assign idx = IDXW'(onehot_to_idx(sel));
  assign any = |onehot;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter with hold limit driving a registered one-hot select
module onehot_rr_arbiter
  import onehot_pkg::*;
#(
  parameter int N = 4,
  parameter int HOLD_MAX = 4,
  parameter int IDXW = $clog2(N)
) (
  input logic clk,
  input logic reset,
  onehot_rr_arbiter_if.master bus
);
  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  state_t state, state_n;
  logic [N-1:0] gnt, gnt_n, a_oh, m_oh;
  logic [IDXW-1:0] idx, idx_n, ptr, ptr_n, a_idx, m_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic a_any, m_any, hold, rotate;
  // The unmasked pick serves idle/release; the masked pick excludes the current holder for forced rotation.
  rr_priority_pick #(.N(N), .IDXW(IDXW)) u_pick_all (
    .req(bus.req_i), .ptr(ptr), .onehot(a_oh), .idx(a_idx), .any(a_any)
  );
  rr_priority_pick #(.N(N), .IDXW(IDXW)) u_pick_others (
    .req(bus.req_i & ~gnt), .ptr(ptr), .onehot(m_oh), .idx(m_idx), .any(m_any)
  );
  assign hold = (state == GRANT) && |(bus.req_i & gnt);
  assign rotate = hold && (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX)) && m_any;
  // Next-state: new grant on idle/release, forced hand-over at the hold limit, otherwise keep and count.
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    idx_n = idx;
    ptr_n = ptr;
    cnt_n = cnt;
    if (!hold) begin
      state_n = a_any ? GRANT : IDLE;
      gnt_n = a_oh;
      idx_n = a_idx;
      cnt_n = a_any ? CW'(1) : '0;
      ptr_n = !a_any ? ptr : (a_idx == IDXW'(N - 1)) ? '0 : a_idx + 1'b1;
    end else if (rotate) begin
      gnt_n = m_oh;
      idx_n = m_idx;
      cnt_n = CW'(1);
      ptr_n = (m_idx == IDXW'(N - 1)) ? '0 : m_idx + 1'b1;
    end else begin
      cnt_n = (HOLD_MAX != 0 && cnt < CW'(HOLD_MAX)) ? cnt + 1'b1 : cnt;
    end
  end
  // State, pointer, counter and registered grant; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt <= '0;
      idx <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      idx <= idx_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  assign bus.gnt_o = gnt;
  assign bus.gnt_valid_o = |gnt;
  assign bus.gnt_idx_o = idx;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed and random checks against a queue-free behavioural arbiter model
module tb_onehot_rr_arbiter;
  localparam int N = 4;
  localparam int HM = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int m_hold = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  always #5 clk = ~clk;
  onehot_rr_arbiter_if #(.N(N)) bus();
  onehot_rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut(.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input int r, input int from);
    for (int i = 0; i < N; i++) if (r[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction
  function automatic int m_gnt();
    return (m_hold < 0) ? 0 : (1 << m_hold);
  endfunction
  // Model: who holds the select after an edge that sampled request vector r.
  task automatic model_step(input int r);
    int k;
    if (m_hold < 0 || !r[m_hold]) k = pick(r, m_ptr);
    else if (HM != 0 && m_cnt == HM && (r & ~(1 << m_hold)) != 0) k = pick(r & ~(1 << m_hold), m_ptr);
    else begin
      if (HM != 0 && m_cnt < HM) m_cnt++;
      return;
    end
    m_hold = k;
    if (k < 0) m_cnt = 0;
    else begin
      m_cnt = 1;
      m_ptr = (k + 1) % N;
    end
  endtask
  // Per-cycle compare of DUT outputs against the model plus the output invariants.
  always @(posedge clk) begin
    int r;
    r = int'(bus.req_i);
    if (!reset) begin
      m_hold = -1;
      m_ptr = 0;
      m_cnt = 0;
    end else model_step(r);
    #1;
    chk("gnt", int'(bus.gnt_o), m_gnt());
    chk("idx", int'(bus.gnt_idx_o), (m_hold < 0) ? 0 : m_hold);
    chk("valid", int'(bus.gnt_valid_o), int'(m_hold >= 0));
    chk("at_most_one", int'($countones(bus.gnt_o) <= 1), 1);
    chk("valid_matches_gnt", int'(bus.gnt_valid_o), int'(|bus.gnt_o));
    if (bus.gnt_valid_o) chk("gnt_is_idx", int'(bus.gnt_o), 1 << bus.gnt_idx_o);
    if (bus.gnt_valid_o && reset) chk("gnt_was_requested", (int'(bus.gnt_o) & r) != 0 ? 1 : 0, 1);
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic apply(input logic [N-1:0] r, input int exp, input string name);
    @(negedge clk);
    bus.req_i = r;
    @(posedge clk);
    #2;
    chk(name, int'(bus.gnt_o), exp);
    chk({name, "_model"}, m_gnt(), exp);
  endtask
  initial begin
    int seq[5];
    bus.req_i = '0;
    do_reset();
    chk("reset_gnt", int'(bus.gnt_o), 0);
    chk("reset_valid", int'(bus.gnt_valid_o), 0);
    chk("reset_idx", int'(bus.gnt_idx_o), 0);
    apply(4'b0101, 1, "first_grant");
    chk("first_idx", int'(bus.gnt_idx_o), 0);
    apply(4'b0100, 4, "back_to_back");
    chk("back_to_back_idx", int'(bus.gnt_idx_o), 2);
    do_reset();
    seq = '{1, 2, 4, 8, 1};
    apply(4'hF, seq[0], "fair_0");
    for (int i = 1; i < 5; i++) apply(4'hF & 4'(~seq[i-1]), seq[i], $sformatf("fair_%0d", i));
    do_reset();
    for (int i = 0; i < 16; i++) apply(4'b0011, ((i / 4) % 2) != 0 ? 2 : 1, $sformatf("hold_%0d", i));
    do_reset();
    for (int i = 0; i < 20; i++) apply(4'b1000, 8, $sformatf("sole_%0d", i));
    do_reset();
    apply(4'b0100, 4, "pre_reset_grant");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset_gnt", int'(bus.gnt_o), 0);
    chk("async_reset_valid", int'(bus.gnt_valid_o), 0);
    bus.req_i = 4'b1100;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("regrant_after_reset", int'(bus.gnt_o), 4);
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.req_i = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that produces the registered one-hot select which the team's one-hot mux consumes; it is the producing end of the one-hot select interface.
- Takes N request lines and issues at most one grant.
- Each grant is held while its requester keeps requesting, up to a programmable hold limit.
- Outputs the one-hot grant plus its binary index, so the downstream mux can be driven either way.

Parameters:
- N, 4, number of requesters (N >= 2).
- HOLD_MAX, 4, maximum consecutive cycles one requester may hold the grant while others wait. 0 = unlimited (no forced rotation).
- IDXW, $clog2(N), width of the binary grant index.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting low clears state immediately.
- req_i  input  N  request vector; bit k high = requester k wants the grant.
- gnt_o  output  N  registered grant; all-zero or exactly one bit set.
- gnt_valid_o  output  1  high when gnt_o is non-zero.
- gnt_idx_o  output  IDXW  binary index of the set bit in gnt_o; 0 when gnt_valid_o is low.

Behaviour:
- Reset (reset low, async):
  - gnt_o=0, gnt_valid_o=0, gnt_idx_o=0.
  - State=IDLE, priority pointer ptr=0, hold counter cnt=0.
  - Outputs remain in this state until the first rising edge after reset goes high.
- States: IDLE, GRANT.
- Selection function: first k with req_i[k]=1, searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- IDLE:
  - If req_i != 0, on the next edge: load gnt_o=onehot(k), gnt_idx_o=k, cnt=1, ptr=(k+1) mod N, state=GRANT.
  - Latency from request to grant is 1 cycle.
  - If req_i == 0, remain in IDLE.
- GRANT with holder h, evaluated each edge:
  - Release (req_i[h]=0):
    - Others pending: re-arbitrate in the same edge using the current ptr, giving a back-to-back new grant with no idle cycle; cnt=1.
    - None pending: gnt_o=0, state=IDLE.
  - Forced rotation (req_i[h]=1, HOLD_MAX!=0, cnt==HOLD_MAX, another req pending): grant passes to the selection among req_i with bit h masked; cnt=1; ptr updated.
  - Otherwise: keep the grant; cnt increments, saturating at HOLD_MAX. A sole requester keeps the grant indefinitely.
- ptr update: ptr=(new_idx+1) mod N on every new grant, including re-grants after release. Wraps N-1 -> 0.
- The grant is never issued to a requester whose req_i bit was low at the sampling edge.
- cnt width is $clog2(HOLD_MAX+1), minimum 1. cnt does not wrap.
- Reset asserted mid-grant drops gnt_o to 0 asynchronously. No partial state is retained.
- Invariants (assertable): $countones(gnt_o)<=1; gnt_valid_o == |gnt_o; gnt_o == (1<<gnt_idx_o) when valid.

Decomposition:
- Shared package (onehot_pkg) holds:
  - state enum {IDLE, GRANT};
  - a function onehot_to_idx;
  - a function rr_select(req, ptr) returning onehot.
- One sub-module is natural: rr_priority_pick, the combinational circular priority picker (req, ptr -> onehot, idx, any). It is reused for both normal and masked selection.
- FSM, ptr, and cnt live in the top module.

Test Plan (N=4, HOLD_MAX=4):
- Reset, then req_i=0101 -> next cycle gnt_o=0001, idx=0. Drop req to 0100 -> next edge gnt_o=0100, idx=2, with no zero cycle.
- Fairness: req_i=1111 with each holder deasserting for exactly the cycle after it is granted -> grant sequence 0001,0010,0100,1000,0001 (wrap).
- Hold limit: req_i=0011 held constant -> gnt_o=0001 for 4 cycles, 0010 for 4 cycles, repeating.
- Sole requester: req_i=1000 constant for 20 cycles -> gnt_o=1000 throughout; cnt saturates at 4; no glitch.
- Mid-grant reset: reset low while gnt_o=0100 -> gnt_o=0 and gnt_valid_o=0 immediately. After release with req_i=1100 -> gnt_o=0100 (ptr restarted at 0).
- Random req_i for 1000 cycles -> invariants hold every cycle; each new grant bit was set in req_i at the prior edge.
